// File: rtl/f_mult_arb_pkg.sv
// Shared types and widths for the f_mult arbiter slice.
package f_mult_arb_pkg;

    // Operand width of the shared double-precision multiplier
    localparam int unsigned FLEN = 64;

    // Requester count limits; tags are sized for the largest legal N_REQ
    localparam int unsigned N_REQ_MAX = 8;
    localparam int unsigned N_REQ_DEF = 4;

    // Default in-flight depth and the matching occupancy counter width
    localparam int unsigned MAX_INFLIGHT_DEF = 4;
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT_DEF) + 1;

    typedef logic [$clog2(N_REQ_MAX)-1:0] tag_t;

    // Occupancy counter width for an arbitrary FIFO depth (holds 0..depth)
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Watchdog counter width able to hold 0..timeout
    function automatic int unsigned wd_cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/f_mult_arb_tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight multiply.
// A pop while full frees a slot for a push in the same cycle.
module f_mult_arb_tag_fifo
    import f_mult_arb_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_INFLIGHT_DEF,
    parameter int unsigned CW    = CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  tag_t push_tag,
    input  logic pop,
    output tag_t head_tag,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tag_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign head_tag = mem[rd_ptr];

    // Storage write; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/f_mult_arbiter.sv
// Round-robin sharing of one f_mult between N_REQ requesters, with in-order
// tag tracking and result routing. Optional watchdog: F_MULT_ARB_WATCHDOG_EN.
module f_mult_arbiter
    import f_mult_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = N_REQ_DEF,
    parameter int unsigned MAX_INFLIGHT   = MAX_INFLIGHT_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0][FLEN-1:0] req_a,
    input  logic [N_REQ-1:0][FLEN-1:0] req_b,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [FLEN-1:0]            rsp_res,
    output logic                       rsp_error,
    output logic                       fpu_up_valid,
    output logic [FLEN-1:0]            fpu_a,
    output logic [FLEN-1:0]            fpu_b,
    input  logic                       fpu_down_valid,
    input  logic [FLEN-1:0]            fpu_res,
    input  logic                       fpu_busy,
    input  logic                       fpu_error,
`ifdef F_MULT_ARB_WATCHDOG_EN
    output logic                       wd_timeout,
`endif
    output logic                       protocol_err
);

    // Configurations the tag width and FIFO pointers cannot represent
    if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_bad_n_req
        $error("f_mult_arbiter: N_REQ must be 2..8");
    end
    if (MAX_INFLIGHT < 2 || (MAX_INFLIGHT & (MAX_INFLIGHT - 1)) != 0) begin : g_bad_depth
        $error("f_mult_arbiter: MAX_INFLIGHT must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("f_mult_arbiter: TIMEOUT_CYCLES must be non-zero");
    end

    tag_t             ptr_q;
    tag_t             winner;
    tag_t             win_hi;
    tag_t             win_lo;
    tag_t             head_tag;
    logic             found_hi;
    logic             found_lo;
    logic             any_valid;
    logic             can_issue;
    logic             grant;
    logic             real_pop;
    logic             wd_fire;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [N_REQ-1:0] rsp_valid_d;
    logic [FLEN-1:0]  rsp_res_d;
    logic             rsp_error_d;

    assign real_pop = fpu_down_valid & ~fifo_empty;
    assign pop      = real_pop | wd_fire;
    // rst gates issue so every output reads 0 while reset is held
    assign can_issue = rst & ~fpu_busy & (~fifo_full | pop);
    assign grant     = any_valid & can_issue;
    assign fpu_up_valid = grant;

    // Round-robin pick: first valid at/after ptr, else first valid below ptr
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_valid[i]) begin
                if (tag_t'(i) >= ptr_q) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        win_hi   = tag_t'(i);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    win_lo   = tag_t'(i);
                end
            end
        end
        winner    = found_hi ? win_hi : win_lo;
        any_valid = found_hi | found_lo;
    end

    // One-hot ready and operand mux for the winning requester
    always_comb begin
        req_ready = '0;
        fpu_a     = '0;
        fpu_b     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant && tag_t'(i) == winner) begin
                req_ready[i] = 1'b1;
                fpu_a        = req_a[i];
                fpu_b        = req_b[i];
            end
        end
    end

    // Pointer moves just past each winner, wrapping at N_REQ
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (grant) begin
            ptr_q <= (winner == tag_t'(N_REQ - 1)) ? '0 : winner + tag_t'(1);
        end
    end

    f_mult_arb_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .CW    (cnt_width(MAX_INFLIGHT))
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (grant),
        .push_tag (winner),
        .pop      (pop),
        .head_tag (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Route a real result, or a watchdog-forced error, to the head tag owner
    always_comb begin
        rsp_valid_d = '0;
        rsp_res_d   = '0;
        rsp_error_d = 1'b0;
        if (pop) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                rsp_valid_d[i] = (tag_t'(i) == head_tag);
            end
            rsp_res_d   = real_pop ? fpu_res : '0;
            rsp_error_d = real_pop ? fpu_error : 1'b1;
        end
    end

    // Response registers: one-cycle pulse, data zero when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= '0;
            rsp_res   <= '0;
            rsp_error <= 1'b0;
        end else begin
            rsp_valid <= rsp_valid_d;
            rsp_res   <= rsp_res_d;
            rsp_error <= rsp_error_d;
        end
    end

    // Sticky flag for a multiplier result with nothing outstanding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            protocol_err <= 1'b0;
        end else if (fpu_down_valid && fifo_empty) begin
            protocol_err <= 1'b1;
        end
    end

`ifdef F_MULT_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = wd_cnt_width(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt;

    // A real result in the firing cycle takes priority over the forced pop
    assign wd_fire = ~fifo_empty & ~real_pop & (wd_cnt == WD_W'(TIMEOUT_CYCLES));

    // Watchdog counts while work is outstanding, restarting on every pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (pop || fifo_empty) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Sticky timeout indication
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_timeout <= 1'b0;
        end else if (wd_fire) begin
            wd_timeout <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_f_mult_arbiter.sv
// Randomized bench for f_mult_arbiter with a behavioural multiplier and
// arbitration/routing reference model.
`timescale 1ns/1ps
module tb_f_mult_arbiter;
    import f_mult_arb_pkg::*;

    localparam int unsigned N_REQ        = 4;
    localparam int unsigned MAX_INFLIGHT = 4;
    localparam int unsigned LAT          = 3;

    typedef struct {
        int unsigned     who;
        logic [FLEN-1:0] res;
        logic            err;
        int unsigned     due;
    } op_t;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ-1:0][FLEN-1:0] req_a;
    logic [N_REQ-1:0][FLEN-1:0] req_b;
    logic [N_REQ-1:0]           rsp_valid;
    logic [FLEN-1:0]            rsp_res;
    logic                       rsp_error;
    logic                       fpu_up_valid;
    logic [FLEN-1:0]            fpu_a;
    logic [FLEN-1:0]            fpu_b;
    logic                       fpu_down_valid;
    logic [FLEN-1:0]            fpu_res;
    logic                       fpu_busy;
    logic                       fpu_error;
    logic                       protocol_err;
`ifdef F_MULT_ARB_WATCHDOG_EN
    logic                       wd_timeout;
`endif

    f_mult_arbiter #(
        .N_REQ          (N_REQ),
        .MAX_INFLIGHT   (MAX_INFLIGHT),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .rsp_valid      (rsp_valid),
        .rsp_res        (rsp_res),
        .rsp_error      (rsp_error),
        .fpu_up_valid   (fpu_up_valid),
        .fpu_a          (fpu_a),
        .fpu_b          (fpu_b),
        .fpu_down_valid (fpu_down_valid),
        .fpu_res        (fpu_res),
        .fpu_busy       (fpu_busy),
        .fpu_error      (fpu_error),
`ifdef F_MULT_ARB_WATCHDOG_EN
        .wd_timeout     (wd_timeout),
`endif
        .protocol_err   (protocol_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [FLEN-1:0] got, input logic [FLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state: outstanding multiplies in issue order, pending requests
    op_t             mq[$];
    bit              pend [N_REQ];
    logic [FLEN-1:0] pa [N_REQ];
    logic [FLEN-1:0] pb [N_REQ];
    int unsigned     mptr = 0;
    int unsigned     cyc  = 0;
    bit              exp_v_cur = 0;
    int unsigned     exp_who_cur = 0;
    logic [FLEN-1:0] exp_res_cur = '0;
    logic            exp_err_cur = 1'b0;
    bit              exp_perr = 0;

    // Stimulus knobs
    logic [N_REQ-1:0] allow_mask = '0;
    int unsigned      p_new  = 0;
    int unsigned      p_busy = 0;
    int unsigned      p_err  = 0;
    bit               hold_mult = 0;
    bit               spurious  = 0;

    // Observations of the DUT
    int unsigned      obs_up = 0;
    int unsigned      obs_grants [N_REQ];
    int unsigned      n_rsp [N_REQ];
    int unsigned      last_issue_cyc = 0;
    int unsigned      last_rsp_cyc = 0;
    logic [N_REQ-1:0] last_rsp_valid = '0;
    logic [FLEN-1:0]  last_rsp_res = '0;
    logic             last_rsp_err = 1'b0;

    function automatic logic [FLEN-1:0] rand_fp();
        logic [10:0] e;
        e = 11'(1013 + $urandom_range(20));
        return {1'($urandom_range(1)), e, 20'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [FLEN-1:0] fmul(input logic [FLEN-1:0] a, input logic [FLEN-1:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    // One clock of stimulus, multiplier model, prediction and comparison
    task automatic step();
        bit               pop_now;
        bit               n_v;
        bit               n_perr;
        int unsigned      n_who;
        logic [FLEN-1:0]  n_res;
        logic             n_err;
        int unsigned      cnt_before;
        bit               can;
        bit               found;
        int unsigned      win;
        logic [N_REQ-1:0] exp_ready;
        logic [N_REQ-1:0] exp_rspv;
        op_t              o;

        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pend[i] && allow_mask[i] && $urandom_range(99) < p_new) begin
                pend[i] = 1;
                pa[i]   = rand_fp();
                pb[i]   = rand_fp();
            end
            req_valid[i] = pend[i];
            req_a[i]     = pa[i];
            req_b[i]     = pb[i];
        end
        fpu_busy   = ($urandom_range(99) < p_busy);
        cnt_before = mq.size();
        pop_now = 0; n_v = 0; n_who = 0; n_res = '0; n_err = 1'b0; n_perr = exp_perr;
        if (spurious) begin
            spurious       = 0;
            fpu_down_valid = 1'b1;
            fpu_res        = {$urandom, $urandom};
            fpu_error      = 1'b1;
            if (mq.size() == 0) n_perr = 1;
        end else if (!hold_mult && mq.size() > 0 && mq[0].due <= cyc) begin
            o              = mq.pop_front();
            fpu_down_valid = 1'b1;
            fpu_res        = o.res;
            fpu_error      = o.err;
            pop_now = 1; n_v = 1; n_who = o.who; n_res = o.res; n_err = o.err;
        end else begin
            fpu_down_valid = 1'b0;
            fpu_res        = {$urandom, $urandom};
            fpu_error      = 1'($urandom_range(1));
        end

        #4;
        can   = !fpu_busy && (cnt_before < MAX_INFLIGHT || pop_now);
        found = 0;
        win   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            int unsigned j;
            j = (mptr + k) % N_REQ;
            if (!found && pend[j]) begin
                found = 1;
                win   = j;
            end
        end
        exp_ready = '0;
        if (can && found) exp_ready[win] = 1'b1;
        exp_rspv = '0;
        if (exp_v_cur) exp_rspv[exp_who_cur] = 1'b1;

        check("req_ready", FLEN'(req_ready), FLEN'(exp_ready));
        check("fpu_up_valid", FLEN'(fpu_up_valid), FLEN'(can && found));
        check("fpu_a", fpu_a, (can && found) ? pa[win] : '0);
        check("fpu_b", fpu_b, (can && found) ? pb[win] : '0);
        check("rsp_valid", FLEN'(rsp_valid), FLEN'(exp_rspv));
        check("rsp_res", rsp_res, exp_v_cur ? exp_res_cur : '0);
        check("rsp_error", FLEN'(rsp_error), FLEN'(exp_v_cur ? exp_err_cur : 1'b0));
        check("protocol_err", FLEN'(protocol_err), FLEN'(exp_perr));

        if (fpu_up_valid) begin
            obs_up++;
            last_issue_cyc = cyc;
            for (int i = 0; i < N_REQ; i++) if (req_ready[i]) obs_grants[i]++;
        end
        if (rsp_valid != '0) begin
            last_rsp_cyc   = cyc;
            last_rsp_valid = rsp_valid;
            last_rsp_res   = rsp_res;
            last_rsp_err   = rsp_error;
            for (int i = 0; i < N_REQ; i++) if (rsp_valid[i]) n_rsp[i]++;
        end

        if (can && found) begin
            o.who = win;
            o.res = fmul(pa[win], pb[win]);
            o.err = ($urandom_range(99) < p_err);
            o.due = cyc + LAT;
            mq.push_back(o);
            pend[win] = 0;
            mptr = (win + 1) % N_REQ;
        end
        exp_v_cur = n_v; exp_who_cur = n_who; exp_res_cur = n_res; exp_err_cur = n_err;
        exp_perr  = n_perr;
    endtask

    task automatic drain(input int unsigned budget);
        p_new = 0;
        for (int i = 0; i < budget && mq.size() != 0; i++) step();
        check("drain_done", FLEN'(mq.size()), '0);
        step();
        step();
    endtask

    int unsigned gmin, gmax, rsp_before, rsp_after;

    initial begin
        req_valid = '0; req_a = '0; req_b = '0;
        fpu_down_valid = 1'b0; fpu_res = '0; fpu_busy = 1'b0; fpu_error = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = 0; pa[i] = '0; pb[i] = '0; obs_grants[i] = 0; n_rsp[i] = 0;
        end

        // Reset values while rst is held low
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", FLEN'(rsp_valid), '0);
        check("reset_rsp_res", rsp_res, '0);
        check("reset_req_ready", FLEN'(req_ready), '0);
        check("reset_up_valid", FLEN'(fpu_up_valid), '0);
        check("reset_protocol_err", FLEN'(protocol_err), '0);
        rst = 1'b1;

        // Single op: 1.0 * 2.0 from requester 0
        allow_mask = 4'b0001; p_err = 0;
        pend[0] = 1; pa[0] = 64'h3FF0000000000000; pb[0] = 64'h4000000000000000;
        repeat (8) step();
        check("p1_res", last_rsp_res, 64'h4000000000000000);
        check("p1_who", FLEN'(last_rsp_valid), FLEN'(4'b0001));
        check("p1_err", FLEN'(last_rsp_err), '0);
        check("p1_latency", FLEN'(last_rsp_cyc - last_issue_cyc), FLEN'(LAT + 1));

        // All requesters continuously valid
        allow_mask = '1; p_new = 100; p_err = 30;
        for (int i = 0; i < N_REQ; i++) obs_grants[i] = 0;
        repeat (40) step();
        gmin = obs_grants[0]; gmax = obs_grants[0];
        for (int i = 1; i < N_REQ; i++) begin
            if (obs_grants[i] < gmin) gmin = obs_grants[i];
            if (obs_grants[i] > gmax) gmax = obs_grants[i];
        end
        check("p2_rr_spread_ok", FLEN'(gmax - gmin <= 1), FLEN'(1));
        check("p2_rr_active", FLEN'(gmin >= 8), FLEN'(1));

        // Multiplier busy for 10 cycles, then released
        p_busy = 100; obs_up = 0;
        repeat (10) step();
        check("p3_busy_no_issue", FLEN'(obs_up), '0);
        p_busy = 0; obs_up = 0;
        step();
        check("p3_issue_on_release", FLEN'(obs_up), FLEN'(1));

        // Fill the tag FIFO with results stalled; pop frees a same-cycle slot
        drain(30);
        hold_mult = 1; p_new = 100; obs_up = 0;
        repeat (6) step();
        check("p4_fill", FLEN'(obs_up), FLEN'(MAX_INFLIGHT));
        hold_mult = 0; obs_up = 0;
        step();
        check("p4_pop_push_same_cycle", FLEN'(obs_up), FLEN'(1));

        // Result with nothing outstanding
        drain(30);
        rsp_before = 0;
        for (int i = 0; i < N_REQ; i++) rsp_before += n_rsp[i];
        spurious = 1;
        repeat (4) step();
        rsp_after = 0;
        for (int i = 0; i < N_REQ; i++) rsp_after += n_rsp[i];
        check("p5_no_rsp", FLEN'(rsp_after - rsp_before), '0);
        check("p5_perr_sticky", FLEN'(protocol_err), FLEN'(1));

        // Reset with three ops in flight
        hold_mult = 1; p_new = 100; obs_up = 0;
        repeat (3) step();
        check("p6_inflight", FLEN'(obs_up), FLEN'(3));
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        #1;
        check("p6_rst_rsp_valid", FLEN'(rsp_valid), '0);
        check("p6_rst_rsp_res", rsp_res, '0);
        check("p6_rst_rsp_error", FLEN'(rsp_error), '0);
        check("p6_rst_req_ready", FLEN'(req_ready), '0);
        check("p6_rst_up_valid", FLEN'(fpu_up_valid), '0);
        check("p6_rst_fpu_a", fpu_a, '0);
        check("p6_rst_protocol_err", FLEN'(protocol_err), '0);
        mq.delete();
        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = 0; n_rsp[i] = 0;
        end
        mptr = 0; exp_v_cur = 0; exp_perr = 0; hold_mult = 0; p_new = 0;
        req_valid = '0; fpu_down_valid = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b1;
        allow_mask = 4'b0100;
        pend[2] = 1; pa[2] = rand_fp(); pb[2] = rand_fp();
        repeat (8) step();
        for (int i = 0; i < N_REQ; i++) begin
            check($sformatf("p6_rsp_count_%0d", i), FLEN'(n_rsp[i]), FLEN'(i == 2 ? 1 : 0));
        end

        // Random traffic
        allow_mask = '1; p_new = 40; p_busy = 20; p_err = 25;
        repeat (400) step();
        p_busy = 0;
        drain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
